// File: rtl/write_back_select.sv
package defines;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_PC4  = 2'd2,
    WB_NONE = 2'd3
  } wb_sel_e;
endpackage

module write_back_select #(
  parameter int DATA_WIDTH = defines::DATA_WIDTH,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  defines::wb_sel_e      WBSel_i,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  input  logic [DATA_WIDTH-1:0] pc_plus4_i,
  input  logic                  wb_valid_i,
  output logic [DATA_WIDTH-1:0] writeback_data_o,
  output logic [DATA_WIDTH-1:0] wb_data_q_o,
  output defines::wb_sel_e      wb_sel_q_o,
  output logic                  wb_valid_q_o
`ifdef WB_SEL_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  cnt_alu_o,
  output logic [CNT_WIDTH-1:0]  cnt_mem_o,
  output logic [CNT_WIDTH-1:0]  cnt_pc4_o,
  output logic [CNT_WIDTH-1:0]  cnt_none_o
`endif
);

  always_comb begin
    writeback_data_o = '0;
    case (WBSel_i)
      defines::WB_ALU: writeback_data_o = alu_result_i;
      defines::WB_MEM: writeback_data_o = rd_data_i;
      defines::WB_PC4: writeback_data_o = pc_plus4_i;
      default:         writeback_data_o = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_data_q_o  <= '0;
      wb_sel_q_o   <= defines::WB_NONE;
      wb_valid_q_o <= 1'b0;
    end else begin
      wb_valid_q_o <= wb_valid_i;
      if (wb_valid_i) begin
        wb_data_q_o <= writeback_data_o;
        wb_sel_q_o  <= WBSel_i;
      end
    end
  end

`ifdef WB_SEL_PERF_CNT_EN
  logic [3:0]           cnt_hit;
  logic [CNT_WIDTH-1:0] cnt_reg [4];

  always_comb begin
    cnt_hit = '0;
    if (wb_valid_i) begin
      case (WBSel_i)
        defines::WB_ALU: cnt_hit[0] = 1'b1;
        defines::WB_MEM: cnt_hit[1] = 1'b1;
        defines::WB_PC4: cnt_hit[2] = 1'b1;
        default:         cnt_hit[3] = 1'b1;
      endcase
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_reg[gi] <= '0;
      end else if (cnt_hit[gi] && (cnt_reg[gi] != '1)) begin
        cnt_reg[gi] <= cnt_reg[gi] + CNT_WIDTH'(1);
      end
    end
  end

  assign cnt_alu_o  = cnt_reg[0];
  assign cnt_mem_o  = cnt_reg[1];
  assign cnt_pc4_o  = cnt_reg[2];
  assign cnt_none_o = cnt_reg[3];
`endif

endmodule

// File: tb/tb_write_back_select.sv
module tb_write_back_select;
  import defines::*;

  localparam int K_WB   = 0;
  localparam int K_DQ   = 1;
  localparam int K_SELQ = 2;
  localparam int K_VQ   = 3;
  localparam int K_CALU = 4;
  localparam int K_CMEM = 5;
  localparam int K_CPC4 = 6;
  localparam int K_CNON = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  wb_sel_e     sel = WB_NONE;
  logic [31:0] alu = '0;
  logic [31:0] rd  = '0;
  logic [31:0] pc4 = '0;
  logic        valid = 1'b0;
  logic [31:0] wb_data;
  logic [31:0] wb_data_q;
  wb_sel_e     wb_sel_q;
  logic        wb_valid_q;
`ifdef WB_SEL_PERF_CNT_EN
  logic [3:0]  cnt_alu, cnt_mem, cnt_pc4, cnt_none;
`endif

  write_back_select #(.CNT_WIDTH(4)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .WBSel_i          (sel),
    .alu_result_i     (alu),
    .rd_data_i        (rd),
    .pc_plus4_i       (pc4),
    .wb_valid_i       (valid),
    .writeback_data_o (wb_data),
    .wb_data_q_o      (wb_data_q),
    .wb_sel_q_o       (wb_sel_q),
    .wb_valid_q_o     (wb_valid_q)
`ifdef WB_SEL_PERF_CNT_EN
    ,
    .cnt_alu_o        (cnt_alu),
    .cnt_mem_o        (cnt_mem),
    .cnt_pc4_o        (cnt_pc4),
    .cnt_none_o       (cnt_none)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb_q[$];
  event chk_ev;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  task automatic expect_val(input int kind, input logic [31:0] exp, input string name);
    chk_t c;
    c.kind = kind;
    c.exp  = exp;
    c.name = name;
    sb_q.push_back(c);
  endtask

  task automatic fire();
    -> chk_ev;
    #1;
  endtask

  task automatic expect_regs(input logic [31:0] d, input wb_sel_e s, input logic v, input string tag);
    expect_val(K_DQ, d, {tag, "_data_q"});
    expect_val(K_SELQ, 32'(s), {tag, "_sel_q"});
    expect_val(K_VQ, 32'(v), {tag, "_valid_q"});
  endtask

  initial begin
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(chk_ev);
      while (sb_q.size() > 0) begin
        c = sb_q.pop_front();
        act = '0;
        case (c.kind)
          K_WB:   act = wb_data;
          K_DQ:   act = wb_data_q;
          K_SELQ: act = 32'(wb_sel_q);
          K_VQ:   act = 32'(wb_valid_q);
`ifdef WB_SEL_PERF_CNT_EN
          K_CALU: act = 32'(cnt_alu);
          K_CMEM: act = 32'(cnt_mem);
          K_CPC4: act = 32'(cnt_pc4);
          K_CNON: act = 32'(cnt_none);
`endif
          default: act = 32'hDEAD_BEEF;
        endcase
        chk_cnt++;
        if (act === c.exp) begin
          pass_cnt++;
          $display("check %-20s got 0x%08h exp 0x%08h ok", c.name, act, c.exp);
        end else begin
          $display("FAIL %-20s got 0x%08h exp 0x%08h", c.name, act, c.exp);
        end
      end
    end
  end

  wb_sel_e     t1_sel [4] = '{WB_ALU, WB_MEM, WB_PC4, WB_NONE};
  logic [31:0] t1_exp [4] = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'h00000000};

  initial begin
    #12;
    expect_regs(32'h0, WB_NONE, 1'b0, "rst");
    fire();
    alu = 32'hAAAAAAAA; rd = 32'hBBBBBBBB; pc4 = 32'hCCCCCCCC;
    sel = WB_MEM;
    #1;
    expect_val(K_WB, 32'hBBBBBBBB, "rst_comb_mem");
    expect_val(K_DQ, 32'h0, "rst_hold_data_q");
    fire();

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = t1_sel[i];
      #1;
      expect_val(K_WB, t1_exp[i], $sformatf("comb_t1_%0d", i));
      fire();
    end

    alu = 32'h12345678; rd = 32'h9ABCDEF0; pc4 = 32'h10203040;
    sel = WB_ALU;
    #1;
    expect_val(K_WB, 32'h12345678, "comb_t2_alu");
    fire();
    sel = WB_MEM;
    #1;
    expect_val(K_WB, 32'h9ABCDEF0, "comb_t2_mem");
    fire();

    @(negedge clk);
    sel = WB_MEM; valid = 1'b1;
    @(posedge clk); #1;
    expect_regs(32'h9ABCDEF0, WB_MEM, 1'b1, "cap_mem");
    fire();
    valid = 1'b0; sel = WB_ALU;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      expect_regs(32'h9ABCDEF0, WB_MEM, 1'b0, $sformatf("hold_%0d", i));
      fire();
    end

    @(negedge clk);
    sel = WB_PC4; valid = 1'b1;
    @(posedge clk); #1;
    expect_regs(32'h10203040, WB_PC4, 1'b1, "cap_pc4");
    fire();
    sel = WB_NONE;
    @(posedge clk); #1;
    expect_regs(32'h0, WB_NONE, 1'b1, "cap_none");
    fire();
    sel = WB_ALU;
    @(posedge clk); #1;
    expect_regs(32'h12345678, WB_ALU, 1'b1, "cap_alu");
    fire();

    #2;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (wb_data_q === 32'h0 && wb_sel_q === WB_NONE && wb_valid_q === 1'b0) begin
      pass_cnt++;
      $display("check %-20s got 0x%08h exp 0x%08h ok", "async_rst_direct", wb_data_q, 32'h0);
    end else begin
      $display("FAIL %-20s got 0x%08h sel %0d valid %0b", "async_rst_direct", wb_data_q, wb_sel_q, wb_valid_q);
    end
    chk_cnt++;
    if (wb_data === 32'h12345678) begin
      pass_cnt++;
      $display("check %-20s got 0x%08h exp 0x%08h ok", "async_rst_comb_dir", wb_data, 32'h12345678);
    end else begin
      $display("FAIL %-20s got 0x%08h exp 0x%08h", "async_rst_comb_dir", wb_data, 32'h12345678);
    end
    expect_regs(32'h0, WB_NONE, 1'b0, "async_rst");
    expect_val(K_WB, 32'h12345678, "async_rst_comb");
    fire();
    @(negedge clk);
    rst = 1'b0; sel = WB_MEM;
    @(posedge clk); #1;
    expect_regs(32'h9ABCDEF0, WB_MEM, 1'b1, "post_rst_cap");
    fire();

`ifdef WB_SEL_PERF_CNT_EN
    @(negedge clk);
    valid = 1'b0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    sel = WB_ALU; valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sel = WB_MEM;
    repeat (2) @(posedge clk);
    #1;
    sel = WB_PC4; valid = 1'b0;
    @(posedge clk); #1;
    expect_val(K_CALU, 32'd3, "cnt_alu");
    expect_val(K_CMEM, 32'd2, "cnt_mem");
    expect_val(K_CPC4, 32'd0, "cnt_pc4");
    expect_val(K_CNON, 32'd0, "cnt_none");
    fire();
    sel = WB_ALU; valid = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    expect_val(K_CALU, 32'd15, "cnt_alu_full");
    fire();
    @(posedge clk); #1;
    expect_val(K_CALU, 32'd15, "cnt_alu_sat");
    fire();
    valid = 1'b0;
`endif

    #1;
    while (sb_q.size() > 0) begin
      chk_t c;
      c = sb_q.pop_front();
      chk_cnt++;
      $display("FAIL %-20s never checked, exp 0x%08h", c.name, c.exp);
    end
    if (pass_cnt == chk_cnt && chk_cnt >= 12) begin
      $display("PASS %0d/%0d checks passed", pass_cnt, chk_cnt);
    end else begin
      $display("FAIL %0d/%0d checks passed", pass_cnt, chk_cnt);
    end
    $finish;
  end

endmodule

// File: doc/write_back_select.md
Name: write_back_select

Overview:
Write-back stage result selector for the RISC-V pipeline. Picks the value written to the register file from three sources: ALU result, load data, or PC+4. The selected value is driven combinationally. A registered copy of the last valid write-back is also kept for trace/debug consumers. Sits between the MEM/WB pipeline register and the register-file write port.

Parameters:
DATA_WIDTH, defines::DATA_WIDTH (32), width of all data paths
CNT_WIDTH, 32, width of each performance counter (optional feature only)

Ports:
clk_i  in  1  pipeline clock, rising edge
rst_i  in  1  asynchronous, active-high reset
WBSel_i  in  wb_sel_e  source select: WB_ALU, WB_MEM, WB_PC4 or WB_NONE (defines package)
alu_result_i  in  DATA_WIDTH  ALU result
rd_data_i  in  DATA_WIDTH  load data from data memory
pc_plus4_i  in  DATA_WIDTH  PC+4 of the instruction (JAL/JALR link)
wb_valid_i  in  1  a retiring instruction is present this cycle
writeback_data_o  out  DATA_WIDTH  selected write-back data (combinational)
wb_data_q_o  out  DATA_WIDTH  registered last valid write-back data
wb_sel_q_o  out  wb_sel_e  registered select of the last valid write-back
wb_valid_q_o  out  1  registered wb_valid_i

Behaviour:
- Combinational path, zero latency, independent of clk_i, rst_i and wb_valid_i:
  - WB_ALU -> alu_result_i
  - WB_MEM -> rd_data_i
  - WB_PC4 -> pc_plus4_i
  - WB_NONE or any unlisted/X encoding -> all zeros
- No latches. The output settles within the same delta-cycle window as the input change.
- Registered path, updated on the rising clk_i edge:
  - wb_valid_q_o <= wb_valid_i.
  - If wb_valid_i=1: wb_data_q_o <= writeback_data_o and wb_sel_q_o <= WBSel_i.
  - If wb_valid_i=0: wb_data_q_o and wb_sel_q_o hold their values.
- While rst_i=1, asynchronously:
  - wb_data_q_o = 0
  - wb_sel_q_o = WB_NONE
  - wb_valid_q_o = 0
- Reset has no effect on writeback_data_o.
- Reset asserted mid-operation clears the registers immediately, without waiting for a clock edge. The first capture after deassertion happens on the first rising edge with rst_i=0.
- A valid WB_NONE cycle captures zero data and a WB_NONE select.

Optional Feature:
Macro WB_SEL_PERF_CNT_EN.
- When defined, four outputs are added, each CNT_WIDTH bits:
  - cnt_alu_o, cnt_mem_o, cnt_pc4_o, cnt_none_o
- Each counter increments by 1 on a rising clk_i edge when wb_valid_i=1 and WBSel_i matches its source. An unlisted encoding counts as none.
- Counters saturate at all-ones; they do not wrap.
- Counters clear to 0 asynchronously on rst_i.
- When not defined, the counter ports and their logic are absent. All other behaviour is identical.

Test Plan:
- alu=0xAAAAAAAA, rd=0xBBBBBBBB, pc4=0xCCCCCCCC; step WB_ALU, WB_MEM, WB_PC4, WB_NONE with #1 settle each -> writeback_data_o = 0xAAAAAAAA, 0xBBBBBBBB, 0xCCCCCCCC, 0x00000000.
- alu=0x12345678, rd=0x9ABCDEF0, pc4=0x10203040; WB_ALU then WB_MEM -> 0x12345678 then 0x9ABCDEF0.
- rst_i=1 with no clock -> wb_data_q_o=0, wb_sel_q_o=WB_NONE, wb_valid_q_o=0; writeback_data_o still follows the select.
- Release reset; WB_MEM with wb_valid_i=1 for one edge, then wb_valid_i=0 with WB_ALU for three edges -> wb_data_q_o=0x9ABCDEF0, wb_sel_q_o=WB_MEM, held; wb_valid_q_o goes 1 then 0.
- Assert rst_i between clock edges after captures -> registers clear immediately, before the next edge.
- With WB_SEL_PERF_CNT_EN: 3 valid ALU, 2 valid MEM, 1 invalid PC4 -> cnt_alu_o=3, cnt_mem_o=2, cnt_pc4_o=0, cnt_none_o=0. Preload CNT_WIDTH=4 to 15 and add another valid ALU -> stays 15.
